// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with grant hold and a
// maximum-tenure timeout.
//
// A requester keeps the grant for as long as it holds its req bit, unless
// another requester is waiting and the owner has already used MAX_HOLD
// cycles. In that case the grant is forced over to the next waiter in
// rotation. All outputs are registered, so there is no combinational path
// from req to gnt.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   req[3:0]  request vector; bit i is held high while requester i needs the resource
//   gnt[3:0]  registered one-hot grant; all-zero when idle
//   gnt_id    index of the granted requester; 0 when idle
//   busy      high while any gnt bit is set
//   hold_cnt  cycles the current owner has held the grant (0 on the first grant cycle)
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    output logic [3:0]        gnt,
    output logic [1:0]        gnt_id,
    output logic              busy,
    output logic [HOLD_W-1:0] hold_cnt
);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t     state;
    logic [1:0] ptr;

    // First set bit of v, searching p, p+1, ... modulo 4. The loop runs from
    // the farthest offset down so the nearest hit is the one that sticks.
    function automatic logic [1:0] sel(input logic [3:0] v, input logic [1:0] p);
        logic [1:0] idx;
        sel = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (v[idx]) sel = idx;
        end
    endfunction

    logic [1:0] nxt_ptr;     // pointer after the current owner releases or is preempted
    logic [3:0] others;      // requests from everyone except the current owner
    logic       at_max;
    logic [1:0] pick_idle;
    logic [1:0] pick_rel;
    logic [1:0] pick_to;

    assign nxt_ptr   = gnt_id + 2'd1;
    assign others    = req & ~gnt;
    assign at_max    = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign pick_idle = sel(req, ptr);
    assign pick_rel  = sel(req, nxt_ptr);
    // The owner is masked out here, so a preempted owner can only come back
    // after the others in rotation have had their turn.
    assign pick_to   = sel(others, nxt_ptr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            gnt      <= 4'b0000;
            gnt_id   <= 2'd0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= OWNED;
                        gnt      <= 4'b0001 << pick_idle;
                        gnt_id   <= pick_idle;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                OWNED: begin
                    if (!req[gnt_id]) begin
                        // Voluntary release: hand off directly if anyone is waiting.
                        ptr <= nxt_ptr;
                        if (|req) begin
                            gnt      <= 4'b0001 << pick_rel;
                            gnt_id   <= pick_rel;
                            hold_cnt <= '0;
                        end else begin
                            state    <= IDLE;
                            gnt      <= 4'b0000;
                            gnt_id   <= 2'd0;
                            busy     <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end else if (at_max) begin
                        // Tenure exhausted: preempt only when someone else waits,
                        // otherwise keep the grant with hold_cnt saturated.
                        if (|others) begin
                            ptr      <= nxt_ptr;
                            gnt      <= 4'b0001 << pick_to;
                            gnt_id   <= pick_to;
                            hold_cnt <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter with grant hold and a maximum-tenure timeout.
- Shares one downstream resource, such as a bus or memory port, between up to four masters.
- Extends the team's two-requester fixed arbiter with fairness rotation, a registered one-hot grant, and forced release of long holders.

Parameters:
MAX_HOLD, 8, max consecutive cycles one requester keeps the grant while others wait (legal range 2..15)
HOLD_W, 4, width of the tenure counter; must satisfy 2^HOLD_W > MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset (asserts immediately, deasserts synchronously by the bench)
req  input  4  request vector; bit i is held high by requester i for as long as it needs the resource
gnt  output 4  registered one-hot grant; all-zero when idle
gnt_id  output 2  index of the granted requester; 0 when idle
busy  output 1  high while any gnt bit is set
hold_cnt  output HOLD_W  cycles the current owner has held the grant, starting at 0 on the first grant cycle

Behaviour:
- Reset (rst=0): gnt=0000, gnt_id=0, busy=0, hold_cnt=0, priority pointer ptr=0, state=IDLE. Reset mid-grant drops the grant at once, with no wait for a clock edge.
- States: IDLE and OWNED. All outputs are registered; there are no combinational paths from req to gnt.
- Selection function sel(v, p): the first set bit of v, searching p, p+1, ... modulo 4.
- IDLE, at an edge with req != 0:
  - gnt <= onehot(sel(req, ptr)), hold_cnt <= 0, go to OWNED.
  - Latency from req sampled high to gnt high is one clock.
- IDLE, at an edge with req == 0: stay in IDLE.
- OWNED, owner o. At each edge exactly one of the following applies:
  - a) req[o]=0 (voluntary release):
    - ptr <= o+1.
    - If req != 0: gnt <= onehot(sel(req, o+1)), hold_cnt <= 0, stay in OWNED. This is a handoff with no dead cycle.
    - If req == 0: gnt <= 0, go to IDLE.
  - b) req[o]=1, hold_cnt == MAX_HOLD-1, and (req & ~onehot(o)) != 0 (timeout):
    - ptr <= o+1, gnt <= onehot(sel(req & ~onehot(o), o+1)), hold_cnt <= 0.
    - The preempted owner keeps its request pending and is re-served in rotation.
  - c) req[o]=1, hold_cnt == MAX_HOLD-1, and no other request: owner keeps the grant and hold_cnt saturates at MAX_HOLD-1. There is no timeout when nobody waits.
  - d) otherwise: hold the grant and set hold_cnt <= hold_cnt+1.
- The pointer only updates on release or timeout, so no requester is skipped.
- Worst-case wait for a continuously asserted request is 3*MAX_HOLD + 1 cycles.
- gnt is always zero or one-hot. gnt_id and busy are consistent with gnt in the same cycle.
- A requester dropping and re-raising req during another's tenure has no effect until arbitration.
- A newly granted requester is one whose req was high at the deciding edge; a request arriving at that same edge is considered.
- ptr wraps 3 -> 0. hold_cnt never exceeds MAX_HOLD-1.

Test Plan:
- Reset: rst=0 with req=1111 for 3 cycles -> gnt=0000, busy=0, hold_cnt=0. Assert rst=0 mid-grant -> gnt=0000 before the next clock edge.
- Single request: after reset req=0100 -> gnt=0100, gnt_id=2 one clock later. Drop req -> gnt=0000 next edge.
- Round robin: req=1111 with each owner dropping its req after 2 granted cycles and re-raising it 1 cycle later -> grant order 0,1,2,3,0 with no idle cycles between grants.
- Timeout: MAX_HOLD=8, req=0011 held constant -> requester 0 gets 8 cycles (hold_cnt 0..7), then requester 1 gets 8, then requester 0 again; the alternation repeats.
- Saturation: req=1000 alone for 20 cycles -> gnt=1000 throughout and hold_cnt stops at 7. Raise req[0] -> gnt=0001 on the next edge.
- Fairness check (random req for 2000 cycles): gnt is always one-hot or zero, and no pending request waits more than 3*MAX_HOLD+1 cycles.
